// File: rtl/onehot_decoder_pkg.sv
// Shared constants for the one-hot decoder: occupancy states and counter width.
package onehot_decoder_pkg;

   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/onehot_dec_core.sv
// Pure combinational binary-to-one-hot decode.
module onehot_dec_core #(
   parameter int unsigned CODE_W = 3
) (
   input  logic [CODE_W-1:0]      in_code,
   output logic [(2**CODE_W)-1:0] onehot_c
);

   localparam int unsigned OUT_W = 2**CODE_W;

   assign onehot_c = OUT_W'(1) << in_code;

endmodule

// File: rtl/onehot_decoder.sv
// One-hot decoder with valid/ready handshake and a two-entry (main + skid) output buffer.
// Optional accepted-code counter port dec_count enabled by macro ONEHOT_DECODER_COUNT_EN.
module onehot_decoder
   import onehot_decoder_pkg::*;
#(
   parameter int unsigned CODE_W = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic [CODE_W-1:0]       in_code,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [(2**CODE_W)-1:0]  out_onehot,
   input  logic                    out_ready
`ifdef ONEHOT_DECODER_COUNT_EN
   ,
   output logic [CNT_W-1:0]        dec_count
`endif
);

   localparam int unsigned OUT_W = 2**CODE_W;

   logic [1:0]       state_q, state_d;
   logic [OUT_W-1:0] main_q, main_d;
   logic [OUT_W-1:0] skid_q, skid_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] dec_c;
   logic             in_xfer_c;
   logic             out_xfer_c;

   onehot_dec_core #(.CODE_W(CODE_W)) u_core (
      .in_code  (in_code),
      .onehot_c (dec_c)
   );

   // Ready depends only on registered occupancy and en, never on out_ready.
   assign in_ready   = rst_n & en & (state_q != ST_TWO);
   assign in_xfer_c  = in_valid & in_ready;
   assign out_xfer_c = valid_q & out_ready;
   assign out_valid  = valid_q;
   assign out_onehot = main_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
      end
   end

   // Emptied registers are zeroed so out_onehot reads 0 whenever out_valid is low.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer_c) begin
               main_d  = dec_c;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer_c && out_xfer_c) begin
               main_d = dec_c;
            end else if (in_xfer_c) begin
               skid_d  = dec_c;
               state_d = ST_TWO;
            end else if (out_xfer_c) begin
               main_d  = '0;
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_xfer_c) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = ST_ONE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
         end
      endcase
      valid_d = (state_d != ST_EMPTY);
   end

`ifdef ONEHOT_DECODER_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of accepted codes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (in_xfer_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign dec_count = cnt_q;
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// Scoreboard bench for onehot_decoder: directed scenarios plus randomized traffic.
module tb_onehot_decoder;

   localparam int unsigned CODE_W = 3;
   localparam int unsigned OUT_W  = 2**CODE_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              in_valid = 1'b0;
   logic [CODE_W-1:0] in_code = '0;
   logic              in_ready;
   logic              out_valid;
   logic [OUT_W-1:0]  out_onehot;
   logic              out_ready = 1'b0;
`ifdef ONEHOT_DECODER_COUNT_EN
   logic [15:0]       dec_count;
   int                cnt_exp = 0;
`endif

   int checks   = 0;
   int failures = 0;

   logic [OUT_W-1:0] sb[$];
   int               occ = 0;
   logic             acc_in = 1'b0;
   logic             acc_out = 1'b0;

   onehot_decoder #(.CODE_W(CODE_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .in_valid   (in_valid),
      .in_code    (in_code),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_onehot (out_onehot),
      .out_ready  (out_ready)
`ifdef ONEHOT_DECODER_COUNT_EN
      ,
      .dec_count  (dec_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Input side: check ready against modelled occupancy, record accepted words.
   always @(negedge clk) begin
      check("in_ready", 32'(in_ready), 32'(rst_n && en && (occ < 2)));
      acc_in = in_valid && in_ready;
      if (acc_in) begin
         sb.push_back(OUT_W'(1) << in_code);
`ifdef ONEHOT_DECODER_COUNT_EN
         if (cnt_exp < 65535) cnt_exp++;
`endif
      end
   end

   // Output monitor: pops expected word on every output transfer.
   always @(negedge clk) begin
      acc_out = 1'b0;
      if (!rst_n) begin
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_onehot", 32'(out_onehot), 32'd0);
      end else begin
         check("out_valid", 32'(out_valid), 32'(occ != 0));
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h expected=none", out_onehot);
            end else begin
               check("out_onehot", 32'(out_onehot), 32'(sb[0]));
               if (out_ready) begin
                  acc_out = 1'b1;
                  void'(sb.pop_front());
               end
            end
         end else begin
            check("idle_onehot_zero", 32'(out_onehot), 32'd0);
         end
      end
   end

   // Occupancy model: words accepted minus words delivered.
   always @(posedge clk) begin
      if (!rst_n) occ = 0;
      else        occ = occ + int'(acc_in) - int'(acc_out);
   end

   task automatic drive(input logic e, input logic v, input int code, input logic r);
      en = e;
      in_valid = v;
      in_code = CODE_W'(code);
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, r);
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // First edge after release must accept; then single code 5.
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 2, 1'b1);
      drive(1'b1, 1'b1, 5, 1'b1);
      idle(3, 1'b1);

      // Back-pressure: two codes fill main and skid, then drain in order.
      drive(1'b1, 1'b1, 0, 1'b0);
      drive(1'b1, 1'b1, 7, 1'b0);
      drive(1'b1, 1'b1, 4, 1'b0);
      idle(3, 1'b0);
      idle(4, 1'b1);

      // Streaming without bubbles.
      for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, k, 1'b1);
      idle(3, 1'b1);

      // en low blocks acceptance.
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 3, 1'b1);
      drive(1'b1, 1'b1, 3, 1'b1);
      idle(3, 1'b1);

      // Asynchronous reset while holding two words.
      drive(1'b1, 1'b1, 1, 1'b0);
      drive(1'b1, 1'b1, 6, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_onehot", 32'(out_onehot), 32'd0);
      sb.delete();
`ifdef ONEHOT_DECODER_COUNT_EN
      cnt_exp = 0;
`endif
      idle(2, 1'b1);
      rst_n = 1'b1;
      idle(4, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, OUT_W - 1)), 1'($urandom_range(0, 2) != 0));
      idle(4, 1'b1);
      check("drained", 32'(sb.size()), 32'd0);

`ifdef ONEHOT_DECODER_COUNT_EN
      for (int i = 0; i < 65540; i++) drive(1'b1, 1'b1, int'($urandom_range(0, OUT_W - 1)), 1'b1);
      idle(2, 1'b1);
      check("count_model", 32'(dec_count), 32'(cnt_exp));
      check("count_sat", 32'(dec_count), 32'hFFFF);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1, 1'b1);
      idle(2, 1'b1);
      check("count_hold", 32'(dec_count), 32'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
